wb_regfile: RTL

Write-back end of the MEM/WB pipeline interface. It consumes the MEM/WB control and data outputs, selects the write-back value, and commits it into a 32-entry integer register file on the clock edge. It serves the two ID-stage read ports with same-cycle write-through bypass. It also exposes the write-back value for the forwarding unit and keeps a retired-write counter for debug and performance checks.

---
 rtl/wb_regfile_pkg.sv | 17 +
 rtl/wb_read_port.sv | 24 ++
 rtl/wb_regfile.sv | 76 +++++++
 3 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared MEM/WB write-back definitions: widths, the x0 address and the bundle
// that MEM_WB hands to the write-back stage.
package wb_regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              RegWrite;
        logic              MemtoReg;
        logic [DATA_W-1:0] ALUresult;
        logic [DATA_W-1:0] Readdata;
        logic [ADDR_W-1:0] RDaddr;
    } wb_bundle_t;

endpackage

// File: rtl/wb_read_port.sv
// One ID-stage read port: x0 forced to zero, same-cycle write-through bypass,
// otherwise the stored register value.
module wb_read_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wb_valid,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] reg_data,
    output logic [DATA_W-1:0] rs_data
);
    import wb_regfile_pkg::REG_ZERO;

    always_comb begin
        rs_data = reg_data;
        if (rs_addr == ADDR_W'(REG_ZERO))
            rs_data = '0;
        else if (wb_valid && (rs_addr == rd_addr))
            rs_data = wb_data;
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and integer register file: selects the WB value, commits it
// on the clock edge, serves two bypassed read ports and counts retired writes.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic [DATA_W-1:0] ALUresult_i,
    input  logic [DATA_W-1:0] Readdata_i,
    input  logic [ADDR_W-1:0] RDaddr_i,
    input  logic [ADDR_W-1:0] RS1addr_i,
    input  logic [ADDR_W-1:0] RS2addr_i,
    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [DATA_W-1:0] WBdata_o,
    output logic              WBvalid_o,
    output logic [CNT_W-1:0]  WBcount_o
);
    import wb_regfile_pkg::REG_ZERO;

    localparam int NUM_REGS  = 2**ADDR_W;
    localparam int NUM_PORTS = 2;

    // x0 has no storage; entries start at 1.
    logic [DATA_W-1:0] regs [1:NUM_REGS-1];

    logic [NUM_PORTS-1:0][ADDR_W-1:0] rs_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] reg_data;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rs_data;

    assign WBdata_o  = MemtoReg_i ? Readdata_i : ALUresult_i;
    assign WBvalid_o = RegWrite_i && (RDaddr_i != ADDR_W'(REG_ZERO)) && rst_i;

    assign rs_addr   = {RS2addr_i, RS1addr_i};
    assign RS1data_o = rs_data[0];
    assign RS2data_o = rs_data[1];

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            reg_data[p] = '0;
            if (rs_addr[p] != ADDR_W'(REG_ZERO))
                reg_data[p] = regs[rs_addr[p]];
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        wb_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_port (
            .rs_addr  (rs_addr[p]),
            .rd_addr  (RDaddr_i),
            .wb_valid (WBvalid_o),
            .wb_data  (WBdata_o),
            .reg_data (reg_data[p]),
            .rs_data  (rs_data[p])
        );
    end

    // WBvalid_o already folds in rst_i, so a write presented during reset is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 1; i < NUM_REGS; i++)
                regs[i] <= '0;
            WBcount_o <= '0;
        end else if (WBvalid_o) begin
            regs[RDaddr_i] <= WBdata_o;
            WBcount_o      <= WBcount_o + CNT_W'(1);
        end
    end

endmodule
